// File: rtl/data_sram_like_bridge.sv
// data_sram_like_bridge
// Turns the core's single-cycle SRAM-style data port into a split-transaction
// SRAM-like request/response handshake. The pipeline is stalled until the
// access completes. Read data is latched so that the pipeline can consume it
// after any other stall source releases.
module data_sram_like_bridge (
   input  logic        clk,
   input  logic        rst,
   // core side
   input  logic        cpu_en,
   input  logic [3:0]  cpu_wen,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        pipe_stall,
   // memory side
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t      state_reg;
   logic        done_reg;
   logic [31:0] rdata_reg;
   logic [1:0]  size_next;
   logic        resp_fire;

   // A response only counts while a transaction is actually outstanding.
   assign resp_fire = (state_reg == ST_WAIT) & mem_data_ok;

   // done_reg blocks re-issue of an access that already finished while the
   // rest of the pipeline is still frozen.
   assign mem_req   = cpu_en & ~done_reg & (state_reg == ST_IDLE);
   assign mem_wr    = |cpu_wen;
   assign mem_addr  = cpu_addr;
   assign mem_wdata = cpu_wdata;
   assign mem_size  = size_next;
   assign cpu_stall = cpu_en & ~done_reg;
   assign cpu_rdata = rdata_reg;

   // Access size from the byte-enable pattern; odd patterns fall back to word.
   always_comb begin
      size_next = 2'd2;
      case (cpu_wen)
         4'b0000, 4'b1111:                   size_next = 2'd2;
         4'b0011, 4'b1100:                   size_next = 2'd1;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: size_next = 2'd0;
         default:                            size_next = 2'd2;
      endcase
   end

   // Transaction FSM, completion flag and response-data latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         done_reg  <= 1'b0;
         rdata_reg <= 32'd0;
      end else begin
         case (state_reg)
            ST_IDLE: if (mem_req && mem_addr_ok) state_reg <= ST_WAIT;
            ST_WAIT: if (mem_data_ok)            state_reg <= ST_IDLE;
            default:                             state_reg <= ST_IDLE;
         endcase

         // Setting wins over clearing so a completion is never lost.
         if (resp_fire)
            done_reg <= 1'b1;
         else if (!pipe_stall)
            done_reg <= 1'b0;

         // Writes also load the latch; the core ignores it for stores.
         if (resp_fire)
            rdata_reg <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Self-checking bench for data_sram_like_bridge: a small memory model answers
// requests with programmable delays, and expected read data is queued when a
// response is driven and popped when the core side sees the access complete.
module tb_data_sram_like_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_en = 1'b0;
   logic [3:0]  cpu_wen = 4'd0;
   logic [31:0] cpu_addr = 32'd0;
   logic [31:0] cpu_wdata = 32'd0;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        pipe_stall = 1'b0;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok = 1'b0;
   logic        mem_data_ok = 1'b0;
   logic [31:0] mem_rdata = 32'd0;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];

   // results of the last access
   int          stall_cycles, handshakes, busy_req, first_req_k;
   logic [1:0]  size_seen;
   logic        wr_seen, timed_out;
   logic [31:0] addr_seen, wdata_seen;

   always #5 clk = ~clk;

   data_sram_like_bridge dut (
      .clk(clk), .rst(rst),
      .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .pipe_stall(pipe_stall),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   // Drives one access from the core side and plays the memory: addr_ok after
   // addr_dly requesting cycles, data_ok data_dly cycles after acceptance.
   // Called just after a rising edge; returns inside the first non-stalled cycle.
   task automatic access(input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input int addr_dly,
                         input int data_dly, input logic [31:0] resp);
      int acc_k;
      acc_k = -1;
      stall_cycles = 0; handshakes = 0; busy_req = 0; first_req_k = -1;
      timed_out = 1'b1;
      size_seen = 2'd3; wr_seen = 1'bx; addr_seen = 32'hx; wdata_seen = 32'hx;
      cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
      for (int k = 0; k < 60; k++) begin
         mem_addr_ok = 1'b0;
         mem_data_ok = 1'b0;
         mem_rdata   = $urandom;
         #1;
         if (!cpu_stall) begin
            timed_out = 1'b0;
            break;
         end
         stall_cycles++;
         if (mem_req && first_req_k < 0) first_req_k = k;
         if (acc_k < 0) begin
            if (mem_req && k >= addr_dly) begin
               mem_addr_ok = 1'b1;
               handshakes++;
               acc_k = k;
               size_seen = mem_size; wr_seen = mem_wr;
               addr_seen = mem_addr; wdata_seen = mem_wdata;
            end
         end else begin
            if (mem_req) busy_req++;
            if (k == acc_k + data_dly) begin
               mem_data_ok = 1'b1;
               mem_rdata   = resp;
               exp_q.push_back(resp);
            end
         end
         @(posedge clk); #1;
      end
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
   endtask

   task automatic next_cycle_idle();
      @(posedge clk); #1;
      cpu_en = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] got;
      #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b want=0", mem_req); end
      n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b want=0", cpu_stall); end
      n_cmp++; if (cpu_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got=%h want=0", cpu_rdata); end
      cpu_en = 1'b1; #1;
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL reset_req_en got=%b want=1", mem_req); end
      n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL reset_stall_en got=%b want=1", cpu_stall); end
      cpu_en = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      got = cpu_rdata;
      $display("reset: rdata=%h", got);
   endtask

   task automatic test_size_decode();
      logic [3:0] wen_t [12] = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010,
                                 4'b0100, 4'b1000, 4'b0101, 4'b0110, 4'b1110, 4'b1001};
      logic [1:0] exp_t [12] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0,
                                 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2};
      for (int i = 0; i < 12; i++) begin
         cpu_wen = wen_t[i]; #1;
         n_cmp++; if (mem_size !== exp_t[i]) begin n_bad++; $display("FAIL size_decode wen=%b got=%0d want=%0d", wen_t[i], mem_size, exp_t[i]); end
         n_cmp++; if (mem_wr !== (wen_t[i] != 4'd0)) begin n_bad++; $display("FAIL wr_decode wen=%b got=%b", wen_t[i], mem_wr); end
         $display("size: wen=%b size=%0d wr=%b", wen_t[i], mem_size, mem_wr);
      end
      cpu_wen = 4'd0;
   endtask

   task automatic test_read_delay();
      logic [31:0] exp;
      access(4'b0000, 32'h0000_1004, 32'd0, 2, 3, 32'hDEAD_BEEF);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL read_timeout got=%b want=0", timed_out); end
      n_cmp++; if (size_seen !== 2'd2) begin n_bad++; $display("FAIL read_size got=%0d want=2", size_seen); end
      n_cmp++; if (wr_seen !== 1'b0) begin n_bad++; $display("FAIL read_wr got=%b want=0", wr_seen); end
      n_cmp++; if (addr_seen !== 32'h0000_1004) begin n_bad++; $display("FAIL read_addr got=%h want=00001004", addr_seen); end
      n_cmp++; if (stall_cycles !== 6) begin n_bad++; $display("FAIL read_stall_cycles got=%0d want=6", stall_cycles); end
      n_cmp++; if (cpu_rdata !== exp) begin n_bad++; $display("FAIL read_rdata got=%h want=%h", cpu_rdata, exp); end
      $display("read: addr=%h stall=%0d rdata=%h", addr_seen, stall_cycles, cpu_rdata);
      next_cycle_idle();
   endtask

   task automatic test_stores();
      logic [31:0] exp;
      access(4'b0100, 32'h0000_2002, 32'h00AB_0000, 1, 2, 32'h0000_0001);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      n_cmp++; if (wr_seen !== 1'b1) begin n_bad++; $display("FAIL byte_wr got=%b want=1", wr_seen); end
      n_cmp++; if (size_seen !== 2'd0) begin n_bad++; $display("FAIL byte_size got=%0d want=0", size_seen); end
      n_cmp++; if (addr_seen !== 32'h0000_2002) begin n_bad++; $display("FAIL byte_addr got=%h want=00002002", addr_seen); end
      n_cmp++; if (wdata_seen !== 32'h00AB_0000) begin n_bad++; $display("FAIL byte_wdata got=%h want=00ab0000", wdata_seen); end
      n_cmp++; if (stall_cycles !== 4) begin n_bad++; $display("FAIL byte_stall_cycles got=%0d want=4", stall_cycles); end
      n_cmp++; if (cpu_rdata !== exp) begin n_bad++; $display("FAIL byte_latch got=%h want=%h", cpu_rdata, exp); end
      $display("byte store: addr=%h size=%0d stall=%0d", addr_seen, size_seen, stall_cycles);
      next_cycle_idle();
      access(4'b1100, 32'h0000_2006, 32'h1234_0000, 0, 1, 32'h0000_0002);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      n_cmp++; if (size_seen !== 2'd1) begin n_bad++; $display("FAIL half_size got=%0d want=1", size_seen); end
      n_cmp++; if (wr_seen !== 1'b1) begin n_bad++; $display("FAIL half_wr got=%b want=1", wr_seen); end
      n_cmp++; if (cpu_rdata !== exp) begin n_bad++; $display("FAIL half_latch got=%h want=%h", cpu_rdata, exp); end
      $display("half store: addr=%h size=%0d stall=%0d", addr_seen, size_seen, stall_cycles);
      next_cycle_idle();
   endtask

   task automatic test_held_pipeline();
      logic [31:0] exp;
      int          extra_req;
      extra_req = 0;
      access(4'b0000, 32'h0000_4000, 32'd0, 1, 1, 32'hCAFE_0001);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      pipe_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin @(posedge clk); #2; end
         if (mem_req) extra_req++;
         n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL held_stall cyc=%0d got=%b want=0", i, cpu_stall); end
         n_cmp++; if (cpu_rdata !== exp) begin n_bad++; $display("FAIL held_rdata cyc=%0d got=%h want=%h", i, cpu_rdata, exp); end
      end
      @(posedge clk); #1; pipe_stall = 1'b0; #1;
      if (mem_req) extra_req++;
      n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL held_release_stall got=%b want=0", cpu_stall); end
      n_cmp++; if (cpu_rdata !== exp) begin n_bad++; $display("FAIL held_release_rdata got=%h want=%h", cpu_rdata, exp); end
      n_cmp++; if (extra_req !== 0) begin n_bad++; $display("FAIL held_rerequest got=%0d want=0", extra_req); end
      $display("held: rdata=%h extra_req=%0d", cpu_rdata, extra_req);
      @(posedge clk); #1;
      access(4'b0000, 32'h0000_4004, 32'd0, 0, 1, 32'hCAFE_0002);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      n_cmp++; if (first_req_k !== 0) begin n_bad++; $display("FAIL held_next_issue got=%0d want=0", first_req_k); end
      n_cmp++; if (cpu_rdata !== exp) begin n_bad++; $display("FAIL held_next_rdata got=%h want=%h", cpu_rdata, exp); end
      $display("held next: first_req=%0d rdata=%h", first_req_k, cpu_rdata);
      next_cycle_idle();
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h0000_3000; mem_addr_ok = 1'b1; #1;
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_req got=%b want=1", mem_req); end
      @(posedge clk); #1; mem_addr_ok = 1'b0; #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_wait_req got=%b want=0", mem_req); end
      rst = 1'b1; #1;
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_req_after got=%b want=1", mem_req); end
      n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL rstmid_stall got=%b want=1", cpu_stall); end
      n_cmp++; if (cpu_rdata !== 32'd0) begin n_bad++; $display("FAIL rstmid_rdata got=%h want=0", cpu_rdata); end
      @(posedge clk); #1; rst = 1'b0; cpu_en = 1'b0;
      mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
      @(posedge clk); #1; mem_data_ok = 1'b0; #1;
      n_cmp++; if (cpu_rdata !== 32'd0) begin n_bad++; $display("FAIL rstmid_stray_rdata got=%h want=0", cpu_rdata); end
      cpu_en = 1'b1; #1;
      n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL rstmid_stray_done got=%b want=1", cpu_stall); end
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle_req got=%b want=1", mem_req); end
      $display("reset mid: rdata=%h stall=%b req=%b", cpu_rdata, cpu_stall, mem_req);
      cpu_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      logic [31:0] exp;
      cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h0000_5000; mem_addr_ok = 1'b1;
      @(posedge clk); #1; mem_addr_ok = 1'b0; cpu_en = 1'b0;
      mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D; exp_q.push_back(32'h0BAD_F00D);
      @(posedge clk); #1; mem_data_ok = 1'b0;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      cpu_en = 1'b1; cpu_addr = 32'h0000_5004; #1;
      n_cmp++; if (cpu_rdata !== exp) begin n_bad++; $display("FAIL flush_rdata got=%h want=%h", cpu_rdata, exp); end
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL flush_done_blocks got=%b want=0", mem_req); end
      @(posedge clk); #2;
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL flush_done_clear got=%b want=1", mem_req); end
      $display("flush: rdata=%h req_after=%b", cpu_rdata, mem_req);
      cpu_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         access(4'b0000, 32'h0000_6000 + 32'(i * 4), 32'd0, 0, 1, d);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
         n_cmp++; if (stall_cycles !== 2) begin n_bad++; $display("FAIL b2b_stall i=%0d got=%0d want=2", i, stall_cycles); end
         n_cmp++; if (busy_req !== 0 || handshakes !== 1) begin n_bad++; $display("FAIL b2b_overlap i=%0d got=%0d/%0d want=0/1", i, busy_req, handshakes); end
         n_cmp++; if (first_req_k !== 0) begin n_bad++; $display("FAIL b2b_issue i=%0d got=%0d want=0", i, first_req_k); end
         n_cmp++; if (cpu_rdata !== exp) begin n_bad++; $display("FAIL b2b_rdata i=%0d got=%h want=%h", i, cpu_rdata, exp); end
         $display("b2b load %0d: addr=%h stall=%0d rdata=%h", i, addr_seen, stall_cycles, cpu_rdata);
         @(posedge clk); #1;
      end
      cpu_en = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_size_decode();
      test_read_delay();
      test_stores();
      test_held_pipeline();
      test_reset_mid();
      test_flush();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
